// File: rtl/regfile_rename_pkg.sv
// Shared sizing constants for the renaming register file.
package regfile_rename_pkg;

  localparam int unsigned REG_NUM       = 32;
  localparam int unsigned REG_ID_BIT    = 5;
  localparam int unsigned ROB_WIDTH_BIT = 4;

  function automatic logic [5:0] popcount(input logic [REG_NUM-1:0] vec);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      cnt = cnt + 6'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One operand query port: x0 forcing, array read and same-cycle commit bypass.
module regfile_read_port
  import regfile_rename_pkg::*;
(
  input  logic [REG_ID_BIT-1:0]                  rs,
  input  logic [REG_NUM-1:0]                     busy_vec,
  input  logic [REG_NUM-1:0][ROB_WIDTH_BIT-1:0]  tag_vec,
  input  logic [REG_NUM-1:0][31:0]               value_vec,
  input  logic                                   write_en,
  input  logic [REG_ID_BIT-1:0]                  reg_id,
  input  logic [ROB_WIDTH_BIT-1:0]               rob_id,
  input  logic [31:0]                            value_in,
  output logic                                   busy,
  output logic [ROB_WIDTH_BIT-1:0]               tag,
  output logic [31:0]                            value
);

  always_comb begin
    busy  = 1'b0;
    tag   = '0;
    value = '0;
    if (rs != '0) begin
      busy  = busy_vec[rs];
      tag   = tag_vec[rs];
      value = value_vec[rs];
      // The pending producer is committing right now: forward its value.
      if (write_en && (reg_id == rs) && busy_vec[rs] && (tag_vec[rs] == rob_id)) begin
        busy  = 1'b0;
        value = value_in;
      end
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register ROB rename tags.
module regfile_rename
  import regfile_rename_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic [REG_ID_BIT-1:0]    rs1,
  input  logic [REG_ID_BIT-1:0]    rs2,
  output logic                     rs1_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
  output logic [31:0]              rs1_value,
  output logic                     rs2_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
  output logic [31:0]              rs2_value,
  input  logic                     rename_en,
  input  logic [REG_ID_BIT-1:0]    rename_rd,
  input  logic [ROB_WIDTH_BIT-1:0] rename_tag,
  input  logic                     write_en,
  input  logic [REG_ID_BIT-1:0]    reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] rob_id,
  input  logic [31:0]              value_in,
  input  logic                     clear_all,
  output logic [5:0]               busy_count
);

  logic [REG_NUM-1:0]                    busy_q, busy_d;
  logic [REG_NUM-1:0][ROB_WIDTH_BIT-1:0] tag_q, tag_d;
  logic [REG_NUM-1:0][31:0]              value_q, value_d;
  logic [5:0]                            busy_count_q;

  always_comb begin
    busy_d  = busy_q;
    tag_d   = tag_q;
    value_d = value_q;
    if (write_en && (reg_id != '0)) begin
      value_d[reg_id] = value_in;
      if (tag_q[reg_id] == rob_id) begin
        busy_d[reg_id] = 1'b0;
      end
    end
    // Rename is applied after commit so it wins on the same register.
    if (clear_all) begin
      busy_d = '0;
    end else if (rename_en && (rename_rd != '0)) begin
      busy_d[rename_rd] = 1'b1;
      tag_d[rename_rd]  = rename_tag;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      tag_q        <= '0;
      value_q      <= '0;
      busy_count_q <= '0;
    end else if (rdy_in) begin
      busy_q       <= busy_d;
      tag_q        <= tag_d;
      value_q      <= value_d;
      busy_count_q <= popcount(busy_d);
    end
  end

  assign busy_count = busy_count_q;

  regfile_read_port u_port1 (
    .rs        (rs1),
    .busy_vec  (busy_q),
    .tag_vec   (tag_q),
    .value_vec (value_q),
    .write_en  (write_en),
    .reg_id    (reg_id),
    .rob_id    (rob_id),
    .value_in  (value_in),
    .busy      (rs1_busy),
    .tag       (rs1_tag),
    .value     (rs1_value)
  );

  regfile_read_port u_port2 (
    .rs        (rs2),
    .busy_vec  (busy_q),
    .tag_vec   (tag_q),
    .value_vec (value_q),
    .write_en  (write_en),
    .reg_id    (reg_id),
    .rob_id    (rob_id),
    .value_in  (value_in),
    .busy      (rs2_busy),
    .tag       (rs2_tag),
    .value     (rs2_value)
  );

endmodule

// File: tb/tb_regfile_rename.sv
// Directed scoreboard bench for regfile_rename: stimulus queues expectations, monitor checks them.
module tb_regfile_rename;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [4:0]  rs1, rs2, rename_rd, reg_id;
  logic [3:0]  rename_tag, rob_id;
  logic        rename_en, write_en, clear_all;
  logic [31:0] value_in;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic [31:0] rs1_value, rs2_value;
  logic [5:0]  busy_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        b1;
    logic [3:0]  t1;
    logic [31:0] v1;
    logic        ct1;
    logic        b2;
    logic [3:0]  t2;
    logic [31:0] v2;
    logic        ct2;
    logic [5:0]  cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  regfile_rename dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs1_tag    (rs1_tag),
    .rs1_value  (rs1_value),
    .rs2_busy   (rs2_busy),
    .rs2_tag    (rs2_tag),
    .rs2_value  (rs2_value),
    .rename_en  (rename_en),
    .rename_rd  (rename_rd),
    .rename_tag (rename_tag),
    .write_en   (write_en),
    .reg_id     (reg_id),
    .rob_id     (rob_id),
    .value_in   (value_in),
    .clear_all  (clear_all),
    .busy_count (busy_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: the DUT answers every cycle, so one queued expectation is consumed per cycle.
  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "rs1_busy", 32'(rs1_busy), 32'(e.b1));
      chk(nm, "rs1_value", rs1_value, e.v1);
      if (e.ct1) chk(nm, "rs1_tag", 32'(rs1_tag), 32'(e.t1));
      chk(nm, "rs2_busy", 32'(rs2_busy), 32'(e.b2));
      chk(nm, "rs2_value", rs2_value, e.v2);
      if (e.ct2) chk(nm, "rs2_tag", 32'(rs2_tag), 32'(e.t2));
      chk(nm, "busy_count", 32'(busy_count), 32'(e.cnt));
    end
  end

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; rs1 = '0; rs2 = '0;
    rename_en = 1'b0; rename_rd = '0; rename_tag = '0;
    write_en = 1'b0; reg_id = '0; rob_id = '0; value_in = '0; clear_all = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_q(input string nm,
                          input logic b1, input logic [3:0] t1, input logic [31:0] v1,
                          input logic ct1,
                          input logic b2, input logic [3:0] t2, input logic [31:0] v2,
                          input logic ct2, input logic [5:0] cnt);
    exp_t e;
    e.b1 = b1; e.t1 = t1; e.v1 = v1; e.ct1 = ct1;
    e.b2 = b2; e.t2 = t2; e.v2 = v2; e.ct2 = ct2; e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] tg);
    rename_en = 1'b1; rename_rd = rd; rename_tag = tg;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
    write_en = 1'b1; reg_id = rd; rob_id = id; value_in = v;
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    tick(); tick();

    idle(); rs1 = 5;
    expect_q("reset_query", 0, 0, 0, 1, 0, 0, 0, 1, 0); tick();
    idle(); rename(3, 7); rs1 = 3;
    expect_q("rename_reads_old", 0, 0, 0, 1, 0, 0, 0, 1, 0); tick();
    idle(); rs1 = 3;
    expect_q("renamed_x3", 1, 7, 0, 1, 0, 0, 0, 1, 1); tick();
    idle(); commit(3, 7, 32'hDEADBEEF); rs1 = 3;
    expect_q("bypass_x3", 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1); tick();
    idle(); rs1 = 3;
    expect_q("committed_x3", 0, 7, 32'hDEADBEEF, 1, 0, 0, 0, 1, 0); tick();

    idle(); rename(4, 2); rs1 = 4;
    expect_q("x4_rename2", 0, 0, 0, 1, 0, 0, 0, 1, 0); tick();
    idle(); rename(4, 5); rs1 = 4;
    expect_q("x4_rename5", 1, 2, 0, 1, 0, 0, 0, 1, 1); tick();
    idle(); commit(4, 2, 32'h11); rs1 = 4;
    expect_q("x4_stale_commit", 1, 5, 0, 1, 0, 0, 0, 1, 1); tick();
    idle(); rs1 = 4;
    expect_q("x4_after_stale", 1, 5, 32'h11, 1, 0, 0, 0, 1, 1); tick();
    idle(); commit(4, 5, 32'h22); rs1 = 4; rs2 = 4;
    expect_q("x4_bypass_both", 0, 0, 32'h22, 0, 0, 0, 32'h22, 0, 1); tick();
    idle(); rs1 = 4;
    expect_q("x4_done", 0, 5, 32'h22, 1, 0, 0, 0, 1, 0); tick();

    idle(); rename(6, 1); rs2 = 6;
    expect_q("x6_rename1", 0, 0, 0, 1, 0, 0, 0, 1, 0); tick();
    idle(); commit(6, 1, 32'h33); rename(6, 9); rs1 = 6; rs2 = 6;
    expect_q("x6_commit_rename", 0, 0, 32'h33, 0, 0, 0, 32'h33, 0, 1); tick();
    idle(); rs1 = 6;
    expect_q("x6_rename_wins", 1, 9, 32'h33, 1, 0, 0, 0, 1, 1); tick();

    idle(); commit(6, 9, 32'h44); rename(1, 0); rs1 = 6; rs2 = 1;
    expect_q("x6_drain_x1_ren", 0, 0, 32'h44, 0, 0, 0, 0, 1, 1); tick();
    idle(); rename(2, 1); rs1 = 1; rs2 = 6;
    expect_q("x2_ren", 1, 0, 0, 1, 0, 9, 32'h44, 1, 1); tick();
    idle(); rename(3, 2); rs1 = 2; rs2 = 3;
    expect_q("x3_ren", 1, 1, 0, 1, 0, 7, 32'hDEADBEEF, 1, 2); tick();
    idle(); clear_all = 1'b1; rename(8, 3); rs1 = 3; rs2 = 8;
    expect_q("clear_issue", 1, 2, 32'hDEADBEEF, 1, 0, 0, 0, 1, 3); tick();
    idle(); rs1 = 8; rs2 = 3;
    expect_q("after_clear", 0, 0, 0, 1, 0, 2, 32'hDEADBEEF, 1, 0); tick();

    idle(); rename(0, 5); commit(0, 0, 32'hFF);
    expect_q("x0_writes", 0, 0, 0, 1, 0, 0, 0, 1, 0); tick();
    idle();
    expect_q("x0_after", 0, 0, 0, 1, 0, 0, 0, 1, 0); tick();

    idle(); rdy_in = 1'b0; rename(9, 4); commit(5, 0, 32'h55); rs1 = 9; rs2 = 5;
    expect_q("stall_issue", 0, 0, 0, 1, 0, 0, 0, 1, 0); tick();
    idle(); rs1 = 9; rs2 = 5;
    expect_q("after_stall", 0, 0, 0, 1, 0, 0, 0, 1, 0); tick();

    idle(); rst_in = 1'b1; rename(10, 3); rs1 = 3; rs2 = 10;
    expect_q("reset_issue", 0, 2, 32'hDEADBEEF, 1, 0, 0, 0, 1, 0); tick();
    idle(); rs1 = 3; rs2 = 10;
    expect_q("after_reset", 0, 0, 0, 1, 0, 0, 0, 1, 0); tick();

    idle();
    tick();
    chk("drain", "pending", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags.
- Consumer end of the ROB commit interface: takes the ROB's write_en / reg_id / rob_id / value_out commit stream and its clear_all flush.
- Producer end of the decoder operand query. For each source register it returns either a committed value or the ROB tag of the pending producer; the tag output drives the ROB's reoder_1 / reoder_2 lookup.
- Records decoder renames at issue time.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired.
- REG_ID_BIT, 5, register index width; taken from const.v.
- ROB_WIDTH_BIT, 4, ROB tag width; taken from const.v.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous reset, active-high
- rdy_in  input  1  pause when low
- rs1  input  REG_ID_BIT  decoder source 1 index
- rs2  input  REG_ID_BIT  decoder source 2 index
- rs1_busy  output  1  high: value pending in ROB entry rs1_tag
- rs1_tag  output  ROB_WIDTH_BIT  pending producer tag (to ROB reoder_1)
- rs1_value  output  32  committed value, valid when rs1_busy=0
- rs2_busy / rs2_tag / rs2_value  output  1 / ROB_WIDTH_BIT / 32  same for source 2 (tag to ROB reoder_2)
- rename_en  input  1  decoder issues an instruction with destination
- rename_rd  input  REG_ID_BIT  destination register
- rename_tag  input  ROB_WIDTH_BIT  ROB id allocated (ROB rob_free_id)
- write_en  input  1  ROB commit strobe
- reg_id  input  REG_ID_BIT  committed destination
- rob_id  input  ROB_WIDTH_BIT  committing ROB entry
- value_in  input  32  committed value
- clear_all  input  1  flush from ROB
- busy_count  output  6  number of registers currently marked busy (debug/verification)

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Storage per register: value[31:0], busy, tag[ROB_WIDTH_BIT-1:0].
- Reset (posedge with rst_in=1): all value=0, busy=0, tag=0; busy_count=0. Query outputs then read busy=0, tag=0, value=0. Reset has priority over rdy_in and every other input, including in the middle of a rename or commit.
- rdy_in=0: no state update. Combinational query outputs remain valid.
- Query path, combinational, zero latency:
  - rsN==0 gives busy=0, value=0, tag=0.
  - Otherwise output busy[rsN], tag[rsN], value[rsN], subject to commit bypass.
- Commit bypass: if write_en && reg_id==rsN && rsN!=0 && busy[rsN] && tag[rsN]==rob_id, the query outputs busy=0 and value=value_in that same cycle.
- Same-cycle rename never affects the query. The decoder reads before its own rename, so rs==rd reads the old mapping.
- Commit (posedge, rdy_in=1, write_en=1, reg_id!=0):
  - value[reg_id] <= value_in, unconditionally; commits arrive in program order.
  - busy cleared only if tag[reg_id]==rob_id and no same-cycle rename of reg_id.
  - A tag mismatch means a newer producer exists; busy and tag are kept.
- Rename (posedge, rdy_in=1, rename_en=1, rename_rd!=0, clear_all=0): busy[rename_rd] <= 1, tag[rename_rd] <= rename_tag.
- Rename and commit to the same register in the same cycle: the value is written and the rename wins, leaving busy=1 with the new tag.
- clear_all=1:
  - All busy <= 0 and rename is ignored.
  - A same-cycle commit still writes its value.
  - Tags are don't-care and are left unchanged.
- Writes or renames targeting x0 are ignored entirely.
- busy_count: registered; equals the popcount of busy after each update. Range 0..31.
- Tag wrap: tags are compared by equality only. A register re-renamed with a wrapped tag equal to an old one is safe, because the ROB cannot hold two live entries with the same id.

Decomposition:
- const.v: REG_ID_BIT, ROB_WIDTH_BIT, REG_NUM. No new typedefs.
- One sub-module, regfile_read_port, instantiated twice. It handles the x0 check, the array read and the commit bypass compare.

Test Plan:
- Reset, then query rs1=5, rs2=0 -> busy=0, value=0, tag=0 for both; busy_count=0.
- Rename rd=3 tag=7; next cycle query rs1=3 -> busy=1, tag=7. Commit reg_id=3 rob_id=7 value_in=0xDEADBEEF with same-cycle query -> bypass busy=0, value=0xDEADBEEF. Next cycle -> stored value, busy=0.
- Rename x4 tag=2, then rename x4 tag=5, then commit x4 rob_id=2 value_in=0x11 -> value=0x11, busy=1, tag=5. Commit rob_id=5 value_in=0x22 -> busy=0, value=0x22.
- Same cycle: commit x6 rob_id=1 value_in=0x33 and rename x6 tag=9 -> value=0x33, busy=1, tag=9. Query rs1=6 that cycle -> bypassed 0x33, busy=0.
- Rename x1, x2, x3 (tags 0, 1, 2), busy_count=3. Assert clear_all together with rename x8 tag=3 -> all busy=0, busy_count=0, x8 not renamed.
- rename_rd=0 and write_en with reg_id=0, value_in=0xFF -> x0 reads 0, busy_count unchanged. rdy_in=0 with rename x9 -> no change.
